// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder and its downstream deserialiser.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter width: holds 0..WIDTH without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_add_core_full_adder.sv
// One-bit full adder used by the bit-serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_core.sv
// Bit-serial unsigned adder: captures two WIDTH-bit operands on load and
// emits their sum LSB first, one bit per cycle, with shift/done framing.
module serial_add_core
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             sum_bit,
   output logic             shift,
   output logic             carry_out,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, a_sh_nxt, b_sh_nxt;
   logic             carry, carry_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             sum_nxt, shift_nxt, carry_out_nxt, busy_nxt, done_nxt;
   logic             fa_s, fa_c;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // Next-state and next-output decode; every output is registered below so
   // nothing combinational reaches a port.
   always_comb begin
      state_nxt     = state;
      a_sh_nxt      = a_sh;
      b_sh_nxt      = b_sh;
      carry_nxt     = carry;
      cnt_nxt       = cnt;
      sum_nxt       = 1'b0;
      shift_nxt     = 1'b0;
      carry_out_nxt = carry_out;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               a_sh_nxt      = a_in;
               b_sh_nxt      = b_in;
               carry_nxt     = 1'b0;
               cnt_nxt       = '0;
               carry_out_nxt = 1'b0;
               busy_nxt      = 1'b1;
               state_nxt     = SHIFT;
            end
         end
         SHIFT: begin
            sum_nxt   = fa_s;
            carry_nxt = fa_c;
            a_sh_nxt  = a_sh >> 1;
            b_sh_nxt  = b_sh >> 1;
            shift_nxt = 1'b1;
            busy_nxt  = 1'b1;
            cnt_nxt   = cnt + 1'b1;
            if (cnt == LAST) begin
               done_nxt      = 1'b1;
               carry_out_nxt = fa_c;
               state_nxt     = DONE;
            end
         end
         DONE: begin
            // load is ignored here; always one idle cycle between operations
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         sum_bit   <= 1'b0;
         shift     <= 1'b0;
         carry_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         a_sh      <= a_sh_nxt;
         b_sh      <= b_sh_nxt;
         carry     <= carry_nxt;
         cnt       <= cnt_nxt;
         sum_bit   <= sum_nxt;
         shift     <= shift_nxt;
         carry_out <= carry_out_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule
